// File: rtl/core_sequencer_pkg.sv
// Shared definitions for the instruction-stage sequencer.
package core_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WRITE  = 3'd5,
        HALT   = 3'd6
    } stage_t;

    function automatic logic is_stage(input stage_t s);
        return (s == FETCH) || (s == DECODE) || (s == EXEC) || (s == MEM) || (s == WRITE);
    endfunction

endpackage

// File: rtl/core_sequencer_stage_timer.sv
// Per-stage wait counter; expired flags the last cycle a stage may still see done.
module stage_timer #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    output logic expired
);
    localparam int CW = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

    logic [CW-1:0] cnt;

    // Cleared in the entry cycle, so in-stage cycle k (k >= 1) holds k-1.
    assign expired = (cnt == CW'(LIMIT - 1));

    always_ff @(posedge clk) begin
        if (rst || clear)
            cnt <= '0;
        else if (tick && !expired)
            cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/core_sequencer.sv
// Five-stage instruction sequencer with per-stage timeout, halt control and perf counters.
module core_sequencer
    import core_sequencer_pkg::*;
#(
    parameter int STAGE_TIMEOUT = 255,
    parameter int CNT_W         = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             halt_req,
    input  logic             fetch_done,
    input  logic             decode_done,
    input  logic             exec_done,
    input  logic             mem_done,
    input  logic             write_done,
    input  logic             skip_mem,
    input  logic             trap,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             exec_en,
    output logic             mem_en,
    output logic             write_en,
    output logic             busy,
    output logic             halted,
    output logic             err,
    output logic [2:0]       err_stage,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);
    stage_t state;
    logic   entry;
    logic   done_sel;
    logic   expired;
    logic   timer_tick;

    assign timer_tick = busy && !entry;

    stage_timer #(.LIMIT(STAGE_TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (entry),
        .tick    (timer_tick),
        .expired (expired)
    );

    assign fetch_en  = entry && (state == FETCH);
    assign decode_en = entry && (state == DECODE);
    assign exec_en   = entry && (state == EXEC);
    assign mem_en    = entry && (state == MEM);
    assign write_en  = entry && (state == WRITE);

    always_comb begin
        done_sel = 1'b0;
        case (state)
            FETCH:   done_sel = fetch_done;
            DECODE:  done_sel = decode_done;
            EXEC:    done_sel = exec_done;
            MEM:     done_sel = mem_done;
            WRITE:   done_sel = write_done;
            default: done_sel = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            entry       <= 1'b0;
            busy        <= 1'b0;
            halted      <= 1'b0;
            err         <= 1'b0;
            err_stage   <= '0;
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
            entry     <= 1'b0;
            if (state == IDLE || state == HALT) begin
                if (start && !err && !(state == HALT && halt_req)) begin
                    state  <= FETCH;
                    entry  <= 1'b1;
                    busy   <= 1'b1;
                    halted <= 1'b0;
                end
            end else if (is_stage(state)) begin
                // done is ignored in the entry cycle and wins over a same-cycle expiry
                if (!entry && done_sel) begin
                    entry <= 1'b1;
                    case (state)
                        FETCH:  state <= DECODE;
                        DECODE: state <= EXEC;
                        EXEC:   state <= trap ? FETCH : (skip_mem ? WRITE : MEM);
                        MEM:    state <= WRITE;
                        default: begin
                            instret_cnt <= instret_cnt + CNT_W'(1);
                            if (halt_req) begin
                                state  <= HALT;
                                entry  <= 1'b0;
                                busy   <= 1'b0;
                                halted <= 1'b1;
                            end else begin
                                state <= FETCH;
                            end
                        end
                    endcase
                end else if (!entry && expired) begin
                    state     <= HALT;
                    busy      <= 1'b0;
                    halted    <= 1'b1;
                    err       <= 1'b1;
                    err_stage <= state;
                end
            end else begin
                state  <= IDLE;
                busy   <= 1'b0;
                halted <= 1'b0;
            end
        end
    end

endmodule

// File: doc/core_sequencer.md
CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 Parameter STAGE_TIMEOUT, default 255, max cycles a stage may wait for done before an error halt.
REQ-002 Parameter CNT_W, default 64, width of cycle and retired-instruction counters.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  begin or resume execution from IDLE/HALT.
REQ-006 halt_req  input  1  request halt at next instruction boundary.
REQ-007 fetch_done, decode_done, exec_done, mem_done, write_done  input  1 each  stage completion levels.
REQ-008 skip_mem  input  1  current instruction has no memory access, sampled with exec_done.
REQ-009 trap  input  1  exec redirects control, sampled with exec_done.
REQ-010 fetch_en, decode_en, exec_en, mem_en, write_en  output  1 each  one-cycle stage enable pulses.
REQ-011 busy  output  1  high in any state other than IDLE/HALT.
REQ-012 halted  output  1  high in HALT.
REQ-013 err  output  1  sticky timeout flag.
REQ-014 err_stage  output  3  stage_t code of the stage that timed out.
REQ-015 cycle_cnt, instret_cnt  output  CNT_W each  mcycle/minstret sources.

Function
REQ-016 FSM states IDLE, FETCH, DECODE, EXEC, MEM, WRITE, HALT; exactly one state at a time.
REQ-017 On entry to a stage state, the matching *_en SHALL be high for exactly the first cycle, low thereafter; at most one *_en high per cycle.
REQ-018 The matching *_done SHALL be ignored in the entry (enable) cycle and sampled from the following cycle on.
REQ-019 Transitions on sampled done: FETCH->DECODE, DECODE->EXEC, MEM->WRITE.
REQ-020 EXEC on exec_done: trap=1 -> FETCH (no MEM/WRITE, no retire); else skip_mem=1 -> WRITE; else MEM; trap has priority.
REQ-021 WRITE on write_done: instret_cnt +1; next state HALT if halt_req=1, else FETCH.
REQ-022 IDLE/HALT: start=1 -> FETCH next cycle; start and halt_req both high in HALT -> remain HALT.
REQ-023 halt_req outside a WRITE-done cycle SHALL be ignored (not latched).
REQ-024 Wait counter SHALL clear on each stage entry and increment each cycle in the stage; reaching STAGE_TIMEOUT without done -> HALT, err=1, err_stage=current stage; done in the same cycle as the limit wins (no error).
REQ-025 err SHALL remain 1 until reset; start from HALT with err=1 SHALL be ignored.
REQ-026 cycle_cnt SHALL increment every cycle out of reset, wrapping modulo 2^CNT_W.
REQ-027 instret_cnt SHALL wrap modulo 2^CNT_W.
REQ-028 Latency: done sampled in cycle N -> next stage enable pulse in cycle N+1.

Reset
REQ-029 rst=1 at a clock edge SHALL force IDLE, all *_en=0, busy=0, halted=0, err=0, err_stage=0, both counters=0, wait counter=0, including mid-stage.
REQ-030 Outputs SHALL hold reset values through the first cycle after rst deasserts.

Structure
REQ-031 stage_t (3-bit enum: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WRITE=5, HALT=6) SHALL live in the shared def package.
REQ-032 Wait counter and timeout compare SHALL be one sub-module, stage_timer (inputs clear, tick; output expired).
REQ-033 All outputs SHALL be registered except *_en, which decode the registered entry flag.

Verification
REQ-034 Reset, start=1 one cycle, each done returned 2 cycles after its en, skip_mem=0 -> en order fetch,decode,exec,mem,write, 3 cycles apart; instret_cnt=1.
REQ-035 skip_mem=1 at exec_done -> no mem_en; write_en next cycle; instret_cnt increments.
REQ-036 trap=1 and skip_mem=1 at exec_done -> fetch_en next cycle; no mem_en/write_en; instret_cnt unchanged.
REQ-037 halt_req=1 at write_done -> halted=1 next cycle, no fetch_en; start=1 -> fetch_en within 1 cycle.
REQ-038 STAGE_TIMEOUT=4, mem_done held 0 -> HALT, err=1, err_stage=4; start ignored; rst clears all.
REQ-039 done held high during enable cycle -> ignored that cycle, transition only on following cycle; rst mid-EXEC -> IDLE, counters 0.
